branch_predictor: RTL and testbench

// - Parametrised successor to the fixed "predict in IF, resolve in EX" scheme: a direct-mapped

---
 rtl/bp_pkg.sv | 43 ++++
 rtl/branch_predictor_if.sv | 36 +++
 rtl/bp_sat_ctr.sv | 17 +
 rtl/branch_predictor.sv | 100 ++++++++++
 tb/tb_branch_predictor.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/bp_pkg.sv
// Shared widths, direction-counter encodings and table entry layout for the branch predictor.
package bp_pkg;
    localparam int DEF_PC_W   = 16;
    localparam int DEF_IDX_W  = 4;
    localparam int DEF_CTR_W  = 2;
    localparam int DEF_PERF_W = 16;
    localparam int DEF_TAG_W  = DEF_PC_W - DEF_IDX_W - 1;

    function automatic int tag_width(input int pc_w, input int idx_w);
        return pc_w - idx_w - 1;
    endfunction

    // Counter encodings generalised to any width: SNT=0..0, WNT=01..1, WT=10..0, ST=1..1.
    function automatic logic [31:0] ctr_min(input int w);
        return (w > 0) ? 32'd0 : 32'd0;
    endfunction
    function automatic logic [31:0] ctr_wnt(input int w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction
    function automatic logic [31:0] ctr_wt(input int w);
        return 32'd1 << (w - 1);
    endfunction
    function automatic logic [31:0] ctr_max(input int w);
        return (32'd1 << w) - 32'd1;
    endfunction

    localparam logic [DEF_CTR_W-1:0] CTR_MIN = DEF_CTR_W'(ctr_min(DEF_CTR_W));
    localparam logic [DEF_CTR_W-1:0] CTR_WNT = DEF_CTR_W'(ctr_wnt(DEF_CTR_W));
    localparam logic [DEF_CTR_W-1:0] CTR_WT  = DEF_CTR_W'(ctr_wt(DEF_CTR_W));
    localparam logic [DEF_CTR_W-1:0] CTR_MAX = DEF_CTR_W'(ctr_max(DEF_CTR_W));

    typedef struct packed {
        logic                 valid;
        logic [DEF_TAG_W-1:0] tag;
        logic [DEF_PC_W-1:0]  target;
        logic [DEF_CTR_W-1:0] ctr;
    } bp_entry_t;

    localparam int ENT_CTR_LSB = 0;
    localparam int ENT_TGT_LSB = ENT_CTR_LSB + DEF_CTR_W;
    localparam int ENT_TAG_LSB = ENT_TGT_LSB + DEF_PC_W;
    localparam int ENT_VLD_BIT = ENT_TAG_LSB + DEF_TAG_W;
endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup, execute resolve and status signals between the pipeline and the predictor.
interface branch_predictor_if #(
    parameter int PC_W   = 16,
    parameter int PERF_W = 16
);
    logic              if_valid;
    logic [PC_W-1:0]   if_pc;
    logic              pred_taken;
    logic [PC_W-1:0]   pred_target;
    logic              ex_valid;
    logic [PC_W-1:0]   ex_pc;
    logic              ex_taken;
    logic [PC_W-1:0]   ex_target;
    logic              ex_pred_taken;
    logic [PC_W-1:0]   ex_pred_target;
    logic              redirect;
    logic [PC_W-1:0]   redirect_pc;
    logic              squash;
    logic [PERF_W-1:0] perf_branches;
    logic [PERF_W-1:0] perf_mispred;
    logic              err;

    modport master (
        output if_valid, if_pc, ex_valid, ex_pc, ex_taken, ex_target,
               ex_pred_taken, ex_pred_target,
        input  pred_taken, pred_target, redirect, redirect_pc, squash,
               perf_branches, perf_mispred, err
    );

    modport slave (
        input  if_valid, if_pc, ex_valid, ex_pc, ex_taken, ex_target,
               ex_pred_taken, ex_pred_target,
        output pred_taken, pred_target, redirect, redirect_pc, squash,
               perf_branches, perf_mispred, err
    );
endinterface

// File: rtl/bp_sat_ctr.sv
// Saturating up/down next-value logic; increment wins if both are requested.
module bp_sat_ctr #(
    parameter int W = 2
) (
    input  logic [W-1:0] q,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] d
);
    always_comb begin
        d = q;
        if (inc && (q != '1))
            d = q + W'(1);
        else if (dec && (q != '0))
            d = q - W'(1);
    end
endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry direction counters, EX-stage resolve/redirect and perf counters.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int PC_W   = DEF_PC_W,
    parameter int IDX_W  = DEF_IDX_W,
    parameter int CTR_W  = DEF_CTR_W,
    parameter int PERF_W = DEF_PERF_W
) (
    input logic               clk,
    input logic               rst,
    branch_predictor_if.slave bp
);
    localparam int DEPTH = 1 << IDX_W;
    localparam int TAG_W = tag_width(PC_W, IDX_W);
    localparam logic [CTR_W-1:0] C_WNT = CTR_W'(ctr_wnt(CTR_W));
    localparam logic [CTR_W-1:0] C_WT  = CTR_W'(ctr_wt(CTR_W));

    logic [DEPTH-1:0]            valid_q;
    logic [DEPTH-1:0][TAG_W-1:0] tag_q;
    logic [DEPTH-1:0][PC_W-1:0]  tgt_q;
    logic [DEPTH-1:0][CTR_W-1:0] ctr_q;

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic             if_hit, ex_hit, upd;
    logic [CTR_W-1:0] ctr_nxt;
    logic [PERF_W-1:0] perf_br_q, perf_br_d, perf_mis_q, perf_mis_d;

    // Lookup reads registered state only, so a same-cycle update to this index is not visible.
    assign if_idx = bp.if_pc[IDX_W:1];
    assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == bp.if_pc[PC_W-1:IDX_W+1]);
    assign bp.pred_taken  = bp.if_valid && if_hit && ctr_q[if_idx][CTR_W-1];
    assign bp.pred_target = bp.pred_taken ? tgt_q[if_idx] : bp.if_pc + PC_W'(2);

    assign bp.redirect = bp.ex_valid &&
                         ((bp.ex_taken != bp.ex_pred_taken) ||
                          (bp.ex_taken && (bp.ex_target != bp.ex_pred_target)));
    assign bp.redirect_pc = bp.ex_taken ? bp.ex_target : bp.ex_pc + PC_W'(2);
    assign bp.squash      = bp.redirect;
    assign bp.err = (bp.if_valid && bp.if_pc[0]) || (bp.ex_valid && bp.ex_pc[0]);

    assign ex_idx = bp.ex_pc[IDX_W:1];
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == bp.ex_pc[PC_W-1:IDX_W+1]);
    assign upd    = bp.ex_valid && !bp.ex_pc[0];

    bp_sat_ctr #(.W(CTR_W)) u_dir_ctr (
        .q   (ctr_q[ex_idx]),
        .inc (bp.ex_taken),
        .dec (!bp.ex_taken),
        .d   (ctr_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            tag_q   <= '0;
            tgt_q   <= '0;
            ctr_q   <= {DEPTH{C_WNT}};
        end else if (upd) begin
            if (ex_hit) begin
                ctr_q[ex_idx] <= ctr_nxt;
                if (bp.ex_taken)
                    tgt_q[ex_idx] <= bp.ex_target;
            end else if (bp.ex_taken) begin
                // Miss-taken evicts whatever alias occupied this slot.
                valid_q[ex_idx] <= 1'b1;
                tag_q[ex_idx]   <= bp.ex_pc[PC_W-1:IDX_W+1];
                tgt_q[ex_idx]   <= bp.ex_target;
                ctr_q[ex_idx]   <= C_WT;
            end
        end
    end

    bp_sat_ctr #(.W(PERF_W)) u_perf_br (
        .q   (perf_br_q),
        .inc (bp.ex_valid),
        .dec (1'b0),
        .d   (perf_br_d)
    );

    bp_sat_ctr #(.W(PERF_W)) u_perf_mis (
        .q   (perf_mis_q),
        .inc (bp.redirect),
        .dec (1'b0),
        .d   (perf_mis_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_br_q  <= '0;
            perf_mis_q <= '0;
        end else begin
            perf_br_q  <= perf_br_d;
            perf_mis_q <= perf_mis_d;
        end
    end

    assign bp.perf_branches = perf_br_q;
    assign bp.perf_mispred  = perf_mis_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed checks of lookup, resolve, counter training, aliasing, perf saturation and reset.
module tb_branch_predictor;
    logic clk = 1'b0;
    logic rst;
    int pass_cnt = 0;
    int tot_cnt  = 0;
    logic [15:0] exp_br  = '0;
    logic [15:0] exp_mis = '0;

    branch_predictor_if #(.PC_W(16), .PERF_W(16)) bpi ();

    branch_predictor #(.PC_W(16), .IDX_W(4), .CTR_W(2), .PERF_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bpi.slave)
    );

    always #5 clk = ~clk;

    task automatic idle();
        bpi.if_valid = 1'b0; bpi.if_pc = '0;
        bpi.ex_valid = 1'b0; bpi.ex_pc = '0; bpi.ex_taken = 1'b0; bpi.ex_target = '0;
        bpi.ex_pred_taken = 1'b0; bpi.ex_pred_target = '0;
    endtask

    task automatic set_ex(input logic [15:0] pc, input logic tk, input logic [15:0] tgt,
                          input logic ptk, input logic [15:0] ptgt);
        bpi.ex_valid = 1'b1; bpi.ex_pc = pc; bpi.ex_taken = tk; bpi.ex_target = tgt;
        bpi.ex_pred_taken = ptk; bpi.ex_pred_target = ptgt;
    endtask

    // Clock one resolve through and track the expected perf totals.
    task automatic step(input logic mis);
        @(posedge clk);
        @(negedge clk);
        bpi.ex_valid = 1'b0;
        if (exp_br != 16'hFFFF) exp_br = exp_br + 16'd1;
        if (mis && exp_mis != 16'hFFFF) exp_mis = exp_mis + 16'd1;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle();
        bpi.if_valid = 1'b1; bpi.if_pc = 16'h0010;
        #12;
        tot_cnt++; if (bpi.pred_taken !== 1'b0) $display("FAIL rst_pred_taken got=%0h exp=0", bpi.pred_taken); else pass_cnt++;
        tot_cnt++; if (bpi.pred_target !== 16'h0012) $display("FAIL rst_pred_target got=%0h exp=0012", bpi.pred_target); else pass_cnt++;
        tot_cnt++; if (bpi.err !== 1'b0) $display("FAIL rst_err got=%0h exp=0", bpi.err); else pass_cnt++;
        tot_cnt++; if (bpi.perf_branches !== 16'h0) $display("FAIL rst_perf_br got=%0h exp=0", bpi.perf_branches); else pass_cnt++;
        tot_cnt++; if (bpi.perf_mispred !== 16'h0) $display("FAIL rst_perf_mis got=%0h exp=0", bpi.perf_mispred); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_alloc();
        set_ex(16'h0010, 1'b1, 16'h0100, 1'b0, 16'h0012);
        #1;
        tot_cnt++; if (bpi.redirect !== 1'b1) $display("FAIL alloc_redirect got=%0h exp=1", bpi.redirect); else pass_cnt++;
        tot_cnt++; if (bpi.squash !== 1'b1) $display("FAIL alloc_squash got=%0h exp=1", bpi.squash); else pass_cnt++;
        tot_cnt++; if (bpi.redirect_pc !== 16'h0100) $display("FAIL alloc_redirect_pc got=%0h exp=0100", bpi.redirect_pc); else pass_cnt++;
        step(1'b1);
        bpi.if_valid = 1'b1; bpi.if_pc = 16'h0010;
        #1;
        tot_cnt++; if (bpi.pred_taken !== 1'b1) $display("FAIL alloc_pred_taken got=%0h exp=1", bpi.pred_taken); else pass_cnt++;
        tot_cnt++; if (bpi.pred_target !== 16'h0100) $display("FAIL alloc_pred_target got=%0h exp=0100", bpi.pred_target); else pass_cnt++;
        tot_cnt++; if (bpi.perf_branches !== 16'd1) $display("FAIL alloc_perf_br got=%0h exp=1", bpi.perf_branches); else pass_cnt++;
    endtask

    task automatic test_ctr();
        set_ex(16'h0010, 1'b0, 16'h0100, 1'b1, 16'h0100);
        #1;
        tot_cnt++; if (bpi.redirect_pc !== 16'h0012) $display("FAIL ctr_nt_redirect_pc got=%0h exp=0012", bpi.redirect_pc); else pass_cnt++;
        step(1'b1);
        #1;
        tot_cnt++; if (bpi.pred_taken !== 1'b0) $display("FAIL ctr_01_pred got=%0h exp=0", bpi.pred_taken); else pass_cnt++;
        set_ex(16'h0010, 1'b0, 16'h0100, 1'b0, 16'h0012);
        #1;
        tot_cnt++; if (bpi.redirect !== 1'b0) $display("FAIL ctr_match_redirect got=%0h exp=0", bpi.redirect); else pass_cnt++;
        step(1'b0);
        #1;
        tot_cnt++; if (bpi.pred_target !== 16'h0012) $display("FAIL ctr_00_target got=%0h exp=0012", bpi.pred_target); else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            set_ex(16'h0010, 1'b1, 16'h0100, 1'b1, 16'h0100);
            step(1'b0);
        end
        #1;
        tot_cnt++; if (bpi.pred_taken !== 1'b1) $display("FAIL ctr_sat_pred got=%0h exp=1", bpi.pred_taken); else pass_cnt++;
        // From 11 one not-taken leaves 10 (still taken); a wrapped counter would predict NT here.
        set_ex(16'h0010, 1'b0, 16'h0100, 1'b1, 16'h0100);
        step(1'b1);
        #1;
        tot_cnt++; if (bpi.pred_taken !== 1'b1) $display("FAIL ctr_nowrap_pred got=%0h exp=1", bpi.pred_taken); else pass_cnt++;
        tot_cnt++; if (bpi.perf_branches !== exp_br) $display("FAIL ctr_perf_br got=%0h exp=%0h", bpi.perf_branches, exp_br); else pass_cnt++;
        tot_cnt++; if (bpi.perf_mispred !== exp_mis) $display("FAIL ctr_perf_mis got=%0h exp=%0h", bpi.perf_mispred, exp_mis); else pass_cnt++;
    endtask

    task automatic test_alias();
        set_ex(16'h0030, 1'b1, 16'h0200, 1'b1, 16'h0100);
        #1;
        tot_cnt++; if (bpi.redirect !== 1'b1) $display("FAIL alias_tgt_redirect got=%0h exp=1", bpi.redirect); else pass_cnt++;
        step(1'b1);
        bpi.if_valid = 1'b1; bpi.if_pc = 16'h0010;
        #1;
        tot_cnt++; if (bpi.pred_taken !== 1'b0) $display("FAIL alias_evict_pred got=%0h exp=0", bpi.pred_taken); else pass_cnt++;
        bpi.if_pc = 16'h0030;
        #1;
        tot_cnt++; if (bpi.pred_target !== 16'h0200) $display("FAIL alias_new_target got=%0h exp=0200", bpi.pred_target); else pass_cnt++;
        bpi.if_pc = 16'hFFFE;
        #1;
        tot_cnt++; if (bpi.pred_target !== 16'h0000) $display("FAIL wrap_target got=%0h exp=0000", bpi.pred_target); else pass_cnt++;
    endtask

    task automatic test_same_cycle();
        @(negedge clk);
        bpi.if_valid = 1'b1; bpi.if_pc = 16'h0030;
        set_ex(16'h0030, 1'b0, 16'h0200, 1'b1, 16'h0200);
        #1;
        tot_cnt++; if (bpi.pred_taken !== 1'b1) $display("FAIL same_old_pred got=%0h exp=1", bpi.pred_taken); else pass_cnt++;
        step(1'b1);
        #1;
        tot_cnt++; if (bpi.pred_taken !== 1'b0) $display("FAIL same_after_pred got=%0h exp=0", bpi.pred_taken); else pass_cnt++;
        set_ex(16'h0030, 1'b1, 16'h0220, 1'b0, 16'h0032);
        #1;
        tot_cnt++; if (bpi.pred_target !== 16'h0032) $display("FAIL same_old_target got=%0h exp=0032", bpi.pred_target); else pass_cnt++;
        step(1'b1);
        #1;
        tot_cnt++; if (bpi.pred_target !== 16'h0220) $display("FAIL same_new_target got=%0h exp=0220", bpi.pred_target); else pass_cnt++;
    endtask

    task automatic test_err();
        bpi.if_valid = 1'b1; bpi.if_pc = 16'h0011;
        #1;
        tot_cnt++; if (bpi.err !== 1'b1) $display("FAIL err_if got=%0h exp=1", bpi.err); else pass_cnt++;
        bpi.if_valid = 1'b0;
        #1;
        tot_cnt++; if (bpi.err !== 1'b0) $display("FAIL err_if_masked got=%0h exp=0", bpi.err); else pass_cnt++;
        set_ex(16'h0031, 1'b1, 16'h0400, 1'b0, 16'h0033);
        #1;
        tot_cnt++; if (bpi.err !== 1'b1) $display("FAIL err_ex got=%0h exp=1", bpi.err); else pass_cnt++;
        step(1'b1);
        bpi.if_valid = 1'b1; bpi.if_pc = 16'h0030;
        #1;
        tot_cnt++; if (bpi.pred_target !== 16'h0220) $display("FAIL err_no_update got=%0h exp=0220", bpi.pred_target); else pass_cnt++;
        tot_cnt++; if (bpi.perf_branches !== exp_br) $display("FAIL err_perf_br got=%0h exp=%0h", bpi.perf_branches, exp_br); else pass_cnt++;
    endtask

    task automatic test_perf_sat();
        int n;
        n = 16'hFFFF - int'(exp_mis);
        for (int i = 0; i < n; i++) begin
            set_ex(16'h0040, 1'b1, 16'h0500, 1'b0, 16'h0042);
            step(1'b1);
        end
        #1;
        tot_cnt++; if (bpi.perf_mispred !== 16'hFFFF) $display("FAIL sat_mis_reach got=%0h exp=ffff", bpi.perf_mispred); else pass_cnt++;
        set_ex(16'h0040, 1'b1, 16'h0500, 1'b0, 16'h0042);
        step(1'b1);
        #1;
        tot_cnt++; if (bpi.perf_mispred !== 16'hFFFF) $display("FAIL sat_mis_hold got=%0h exp=ffff", bpi.perf_mispred); else pass_cnt++;
        tot_cnt++; if (bpi.perf_branches !== exp_br) $display("FAIL sat_br_hold got=%0h exp=%0h", bpi.perf_branches, exp_br); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        set_ex(16'h0030, 1'b1, 16'h0600, 1'b0, 16'h0032);
        bpi.if_valid = 1'b1; bpi.if_pc = 16'h0040;
        #2;
        rst = 1'b1;
        #1;
        tot_cnt++; if (bpi.perf_branches !== 16'h0) $display("FAIL mid_perf_br got=%0h exp=0", bpi.perf_branches); else pass_cnt++;
        tot_cnt++; if (bpi.perf_mispred !== 16'h0) $display("FAIL mid_perf_mis got=%0h exp=0", bpi.perf_mispred); else pass_cnt++;
        tot_cnt++; if (bpi.pred_target !== 16'h0042) $display("FAIL mid_miss_40 got=%0h exp=0042", bpi.pred_target); else pass_cnt++;
        @(posedge clk);
        #1;
        tot_cnt++; if (bpi.perf_branches !== 16'h0) $display("FAIL mid_edge_perf_br got=%0h exp=0", bpi.perf_branches); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0; bpi.ex_valid = 1'b0; bpi.if_pc = 16'h0030;
        #1;
        tot_cnt++; if (bpi.pred_taken !== 1'b0) $display("FAIL mid_discard_pred got=%0h exp=0", bpi.pred_taken); else pass_cnt++;
        tot_cnt++; if (bpi.pred_target !== 16'h0032) $display("FAIL mid_discard_target got=%0h exp=0032", bpi.pred_target); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_alloc();
        test_ctr();
        test_alias();
        test_same_cycle();
        test_err();
        test_perf_sat();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
